// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sequencer sharing one start/done multiplier among NUM_REQ clients
// Optional watchdog enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_share_arbiter #(
    parameter int BIT_LEN = 4,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*BIT_LEN-1:0] a_flat,
    input  logic [NUM_REQ*BIT_LEN-1:0] b_flat,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [2*BIT_LEN-1:0]       res,
    output logic                       busy,
    output logic [BIT_LEN-1:0]         mul_in1,
    output logic [BIT_LEN-1:0]         mul_in2,
    output logic                       mul_start,
    input  logic [2*BIT_LEN-1:0]       mul_out,
    input  logic                       mul_done,
    output logic                       err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_first;
    logic [NUM_REQ-1:0]     r_grant;
    logic [NUM_REQ-1:0]     r_done;
    logic [2*BIT_LEN-1:0]   r_res;
    logic                   r_busy;
    logic [BIT_LEN-1:0]     r_in1;
    logic [BIT_LEN-1:0]     r_in2;
    logic                   r_start;

    logic                   w_found;
    logic [IDX_W-1:0]       w_sel;
    logic [NUM_REQ-1:0]     w_sel_oh;
    logic                   w_accept;

    // Scan from the pointer upward with wrap-around; first set request wins.
    always_comb begin
        int j;
        w_found  = 1'b0;
        w_sel    = '0;
        w_sel_oh = '0;
        j        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!w_found && req[j]) begin
                w_found     = 1'b1;
                w_sel       = IDX_W'(j);
                w_sel_oh    = '0;
                w_sel_oh[j] = 1'b1;
            end
        end
    end

    // The first WAIT cycle may still see the previous operation's done level.
    assign w_accept = !r_first && mul_done;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_first <= 1'b0;
            r_grant <= '0;
            r_done  <= '0;
            r_res   <= '0;
            r_busy  <= 1'b0;
            r_in1   <= '0;
            r_in2   <= '0;
            r_start <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
            r_to_cnt <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_sel_oh;
                        r_idx   <= w_sel;
                        r_in1   <= a_flat[int'(w_sel)*BIT_LEN +: BIT_LEN];
                        r_in2   <= b_flat[int'(w_sel)*BIT_LEN +: BIT_LEN];
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_start <= 1'b0;
                    r_first <= 1'b1;
`ifdef MUL_ARB_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_first <= 1'b0;
                    if (w_accept) begin
                        r_res   <= mul_out;
                        r_done  <= r_grant;
                        r_state <= S_DONE;
                    end
`ifdef MUL_ARB_TIMEOUT_EN
                    // Give up after TIMEOUT WAIT cycles; the client still gets its done pulse.
                    else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_done  <= r_grant;
                        r_state <= S_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    if (int'(r_idx) == NUM_REQ - 1) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_idx + 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign done      = r_done;
    assign res       = r_res;
    assign busy      = r_busy;
    assign mul_in1   = r_in1;
    assign mul_in2   = r_in2;
    assign mul_start = r_start;

`ifdef MUL_ARB_TIMEOUT_EN
    assign err = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign err = 1'b0;
`endif

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Round-robin arbiter/sequencer sharing one Booth multiplier (CU/DP pair, start/done handshake) among NUM_REQ requesters.
- Grants one requester, latches its operands and pulses the multiplier start; waits for multiplier done, then returns the product with a one-hot done pulse.
- Sits between client logic and the single multiplier instance.

Parameters:
- BIT_LEN, 4, operand width; product is 2*BIT_LEN, signed two's complement.
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, watchdog limit in cycles; used only with MUL_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester request level.
- a_flat  in  NUM_REQ*BIT_LEN  operand A; requester i at [i*BIT_LEN +: BIT_LEN].
- b_flat  in  NUM_REQ*BIT_LEN  operand B, same packing.
- grant  out  NUM_REQ  one-hot; high from grant cycle until done cycle inclusive.
- done  out  NUM_REQ  one-hot, one-cycle pulse when the product is valid.
- res  out  2*BIT_LEN  last product; held until next completion.
- busy  out  1  high in any state other than IDLE.
- mul_in1  out  BIT_LEN  multiplier operand 1 (latched A).
- mul_in2  out  BIT_LEN  multiplier operand 2 (latched B).
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_out  in  2*BIT_LEN  multiplier product.
- mul_done  in  1  multiplier result-ready flag (level).
- err  out  1  timeout flag (tied 0 without MUL_ARB_TIMEOUT_EN).

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; grant=0, done=0, res=0, busy=0, mul_in1=0, mul_in2=0, mul_start=0, err=0; round-robin pointer=0. Reset mid-operation abandons the transaction with no done pulse. The top level resets the multiplier from the same source, inverted to its active-low reset.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE:
  - If req!=0, select the first set bit scanning from pointer upward with wrap-around; set grant[i].
  - Latch a_i into mul_in1 and b_i into mul_in2; go to START.
  - If req=0, stay in IDLE.
- START: mul_start=1 for exactly this cycle; operands stay stable. Go to WAIT.
- WAIT:
  - Ignore mul_done in the first WAIT cycle, because the flag may be stale from the previous operation.
  - From the second WAIT cycle on, mul_done=1 means res<=mul_out and the state goes to DONE.
- DONE:
  - done[i]=1 for one cycle; grant[i] is still high during this cycle.
  - pointer <= (i+1) mod NUM_REQ; go to IDLE, and grant clears on that edge.
- Latency: grant edge to done pulse = 3 + multiplier cycles. No back-to-back overlap; at most one operation is in flight.
- Requester rules:
  - Hold req high until done[i] is seen, and drop it in the cycle after done.
  - Operands are sampled only at grant, so later changes are ignored.
  - If req[i] is still high in IDLE after done, it is a new request. Round robin gives the other pending requesters priority first.
- Dropping req[i] while granted does not abort; the operation completes and done[i] still pulses.
- Simultaneous requests: strict rotation from pointer. Every requester is served within NUM_REQ operations.
- mul_done is never sampled in IDLE, START or DONE.

Optional Feature:
- Macro: MUL_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without mul_done: err=1 (sticky until rst), res unchanged, done[i] pulses, state goes to DONE and then IDLE; pointer advances normally.
  - err is cleared only by rst.
- Undefined: no counter; err tied 0; WAIT waits indefinitely.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 -> all outputs 0, busy=0, mul_start never asserted.
- Single request: req=4'b0010, a1=3, b1=5 -> grant=0010 next edge; one-cycle mul_start with mul_in1=3, mul_in2=5; done=0010 pulse; res=8'h0F.
- Signed product: req0, a0=4'hE (-2), b0=4'h7 -> res=8'hF2 (-14); done=0001.
- Round robin: req=4'b1111 held, each requester dropping req after its done -> grants in order 0001, 0010, 0100, 1000; pointer wraps; then req0 again is served first.
- Reset mid-op: req2 granted; rst asserted in WAIT -> next cycle state IDLE, grant=0, no done pulse, pointer=0.
- Timeout (MUL_ARB_TIMEOUT_EN, TIMEOUT=8): model holds mul_done=0 -> after 8 WAIT cycles err=1, done pulses for the granted requester, res unchanged, arbiter serves the next request.
